// File: rtl/rr_stream_mux_pkg.sv
// Shared types and limits for the round-robin stream multiplexer.
// Imported by the arbiter and the top level.
package rr_stream_mux_pkg;

    typedef enum logic {
        ARB_RR    = 1'b0,
        ARB_FIXED = 1'b1
    } arb_mode_t;

    localparam int unsigned MIN_CH = 2;
    localparam int unsigned MAX_CH = 16;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational arbiter: picks the first requester at or after a start index,
// where the start is ptr in round-robin mode and 0 in fixed-priority mode.
module rr_arbiter
    import rr_stream_mux_pkg::*;
#(
    parameter  int unsigned N_CH = 4,
    localparam int unsigned CH_W = $clog2(N_CH)
) (
    input  logic [N_CH-1:0] req,
    input  logic [CH_W-1:0] ptr,
    input  logic            mode,
    output logic [N_CH-1:0] grant,
    output logic [CH_W-1:0] grant_idx,
    output logic            any_grant
);

    always_comb begin
        int unsigned start;
        int unsigned idx;
        logic [CH_W-1:0] cidx;
        grant     = '0;
        grant_idx = '0;
        any_grant = 1'b0;
        start     = (arb_mode_t'(mode) == ARB_FIXED) ? 0 : 32'(ptr);
        // Explicit wrap so non-power-of-two channel counts stay in range
        for (int unsigned off = 0; off < N_CH; off++) begin
            idx = start + off;
            if (idx >= N_CH) begin
                idx = idx - N_CH;
            end
            cidx = CH_W'(idx);
            if (!any_grant && req[cidx]) begin
                any_grant   = 1'b1;
                grant_idx   = cidx;
                grant[cidx] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/rr_stream_mux.sv
// N-channel valid/ready stream multiplexer with a one-entry registered output
// stage tagged with the source channel index.
module rr_stream_mux
    import rr_stream_mux_pkg::*;
#(
    parameter  int unsigned N_CH  = 4,
    parameter  int unsigned WIDTH = 4,
    localparam int unsigned CH_W  = $clog2(N_CH)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  mode,
    input  logic [N_CH-1:0]       in_valid,
    input  logic [N_CH*WIDTH-1:0] in_data,
    output logic [N_CH-1:0]       in_ready,
    output logic                  out_valid,
    output logic [WIDTH-1:0]      out_data,
    output logic [CH_W-1:0]       out_ch,
    input  logic                  out_ready
);

    if (N_CH < MIN_CH || N_CH > MAX_CH) begin : g_bad_nch
        $error("rr_stream_mux: N_CH out of supported range");
    end

    logic             valid_q;
    logic [WIDTH-1:0] data_q;
    logic [CH_W-1:0]  ch_q;
    logic [CH_W-1:0]  ptr_q, ptr_d;

    logic [N_CH-1:0]  grant;
    logic [CH_W-1:0]  grant_idx;
    logic             any_grant;
    logic             load;
    logic             xfer;
    logic [WIDTH-1:0] sel_data;

    rr_arbiter #(
        .N_CH (N_CH)
    ) u_arb (
        .req       (in_valid),
        .ptr       (ptr_q),
        .mode      (mode),
        .grant     (grant),
        .grant_idx (grant_idx),
        .any_grant (any_grant)
    );

    // Output stage takes a word when empty or being drained this cycle
    assign load     = !valid_q || out_ready;
    assign xfer     = load && any_grant;
    assign in_ready = (rst_n && load) ? grant : '0;

    always_comb begin
        sel_data = '0;
        for (int unsigned i = 0; i < N_CH; i++) begin
            if (grant[i]) begin
                sel_data = in_data[i*WIDTH +: WIDTH];
            end
        end
    end

    assign ptr_d = (grant_idx == CH_W'(N_CH - 1)) ? '0 : grant_idx + 1'b1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= 1'b0;
            data_q  <= '0;
            ch_q    <= '0;
            ptr_q   <= '0;
        end else if (xfer) begin
            valid_q <= 1'b1;
            data_q  <= sel_data;
            ch_q    <= grant_idx;
            ptr_q   <= ptr_d;
        end else if (out_ready) begin
            valid_q <= 1'b0;
        end
    end

    assign out_valid = valid_q;
    assign out_data  = data_q;
    assign out_ch    = ch_q;

endmodule

// File: tb/tb_rr_stream_mux.sv
// Self-checking bench: a 4-channel and a 3-channel instance checked every cycle
// against a queue-free behavioural model of the arbitration rules.
module tb_rr_stream_mux;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        mode_a, mode_b, rdy_a, rdy_b;
    logic [3:0]  v_a;
    logic [15:0] d_a;
    logic [2:0]  v_b;
    logic [11:0] d_b;
    logic [3:0]  ir_a;
    logic        ov_a;
    logic [3:0]  od_a;
    logic [1:0]  oc_a;
    logic [2:0]  ir_b;
    logic        ov_b;
    logic [3:0]  od_b;
    logic [1:0]  oc_b;

    int n_assert = 0;
    int n_fail   = 0;

    bit         m_valid[2];
    logic [3:0] m_data[2];
    int         m_ch[2];
    int         m_ptr[2];
    int         last_g[2];

    always #5 clk = ~clk;

    rr_stream_mux #(.N_CH(4), .WIDTH(4)) u_dut_a (
        .clk       (clk),
        .rst_n     (rst_n),
        .mode      (mode_a),
        .in_valid  (v_a),
        .in_data   (d_a),
        .in_ready  (ir_a),
        .out_valid (ov_a),
        .out_data  (od_a),
        .out_ch    (oc_a),
        .out_ready (rdy_a)
    );

    rr_stream_mux #(.N_CH(3), .WIDTH(4)) u_dut_b (
        .clk       (clk),
        .rst_n     (rst_n),
        .mode      (mode_b),
        .in_valid  (v_b),
        .in_data   (d_b),
        .in_ready  (ir_b),
        .out_valid (ov_b),
        .out_data  (od_b),
        .out_ch    (oc_b),
        .out_ready (rdy_b)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // First valid channel at or after the start index, wrapping modulo n; -1 if none
    function automatic int pick(input int n, input logic [15:0] v, input int p, input bit fixed);
        int start;
        start = fixed ? 0 : p;
        for (int off = 0; off < n; off++) begin
            if (v[(start + off) % n]) return (start + off) % n;
        end
        return -1;
    endfunction

    task automatic model_reset();
        for (int d = 0; d < 2; d++) begin
            m_valid[d] = 1'b0;
            m_data[d]  = '0;
            m_ch[d]    = 0;
            m_ptr[d]   = 0;
            last_g[d]  = -1;
        end
    endtask

    // Called at a negedge with inputs already driven; returns at the next negedge
    task automatic tick();
        int          n[2];
        logic [15:0] v[2];
        logic [63:0] dat[2];
        bit          md[2], rd[2], ld[2];
        int          g[2];
        logic [31:0] exp_rdy;
        n[0] = 4; n[1] = 3;
        v[0] = 16'(v_a);   v[1] = 16'(v_b);
        dat[0] = 64'(d_a); dat[1] = 64'(d_b);
        md[0] = mode_a;    md[1] = mode_b;
        rd[0] = rdy_a;     rd[1] = rdy_b;
        #1;
        for (int d = 0; d < 2; d++) begin
            ld[d] = !m_valid[d] || rd[d];
            g[d]  = pick(n[d], v[d], m_ptr[d], md[d]);
            exp_rdy = (ld[d] && g[d] >= 0) ? (32'd1 << g[d]) : 32'd0;
            if (d == 0) chk("in_ready_a", 32'(ir_a), exp_rdy);
            else        chk("in_ready_b", 32'(ir_b), exp_rdy);
        end
        @(posedge clk);
        for (int d = 0; d < 2; d++) begin
            if (ld[d] && g[d] >= 0) begin
                m_valid[d] = 1'b1;
                m_data[d]  = 4'((dat[d] >> (g[d] * 4)) & 64'hF);
                m_ch[d]    = g[d];
                m_ptr[d]   = (g[d] + 1) % n[d];
                last_g[d]  = g[d];
            end else begin
                if (rd[d]) m_valid[d] = 1'b0;
                last_g[d] = -1;
            end
        end
        #1;
        chk("out_valid_a", 32'(ov_a), 32'(m_valid[0]));
        chk("out_data_a",  32'(od_a), 32'(m_data[0]));
        chk("out_ch_a",    32'(oc_a), 32'(m_ch[0]));
        chk("out_valid_b", 32'(ov_b), 32'(m_valid[1]));
        chk("out_data_b",  32'(od_b), 32'(m_data[1]));
        chk("out_ch_b",    32'(oc_b), 32'(m_ch[1]));
        @(negedge clk);
    endtask

    initial begin
        rst_n  = 1'b0;
        mode_a = 1'b0; mode_b = 1'b0;
        rdy_a  = 1'b1; rdy_b  = 1'b1;
        v_a = 4'hF; d_a = 16'h4321;
        v_b = 3'h0; d_b = 12'h0;
        model_reset();

        // Reset and idle
        #1;
        chk("rst_in_ready", 32'(ir_a), 32'h0);
        chk("rst_out_valid", 32'(ov_a), 32'h0);
        chk("rst_out_data", 32'(od_a), 32'h0);
        @(negedge clk);
        @(negedge clk);
        v_a   = 4'h0;
        rst_n = 1'b1;
        tick();
        tick();

        // Round-robin fairness, one word per cycle
        v_a = 4'hF; d_a = 16'h4321; mode_a = 1'b0; rdy_a = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("rr_seq_ch", 32'(oc_a), 32'(i % 4));
            chk("rr_seq_data", 32'(od_a), 32'(i % 4 + 1));
        end

        // Fixed priority
        mode_a = 1'b1; v_a = 4'b1010; d_a = 16'h9070;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("fixed_ch1", 32'(oc_a), 32'd1);
        end
        v_a = 4'b1000;
        tick();
        chk("fixed_ch3", 32'(oc_a), 32'd3);

        // Backpressure
        mode_a = 1'b0; v_a = 4'b0001; d_a = 16'h0005;
        tick();
        chk("bp_load", 32'(od_a), 32'h5);
        v_a = 4'b0100; d_a = 16'h0A00; rdy_a = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("bp_in_ready", 32'(ir_a), 32'h0);
            chk("bp_hold_data", 32'(od_a), 32'h5);
            chk("bp_hold_ch", 32'(oc_a), 32'h0);
        end
        rdy_a = 1'b1;
        tick();
        chk("bp_release_data", 32'(od_a), 32'hA);
        chk("bp_release_ch", 32'(oc_a), 32'h2);
        v_a = 4'h0;
        tick();

        // Non-power-of-two wrap on the 3-channel instance
        v_b = 3'b100; d_b = 12'h600;
        tick();
        chk("wrap_ch2", 32'(oc_b), 32'd2);
        v_b = 3'b111; d_b = 12'h321;
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("wrap_seq", 32'(oc_b), 32'(i % 3));
        end
        v_b = 3'b000;
        tick();

        // Async reset mid-stream
        v_a = 4'hF; rdy_a = 1'b0;
        tick();
        #2 rst_n = 1'b0;
        #1;
        chk("async_out_valid", 32'(ov_a), 32'h0);
        chk("async_in_ready", 32'(ir_a), 32'h0);
        chk("async_out_data", 32'(od_a), 32'h0);
        model_reset();
        @(negedge clk);
        rst_n = 1'b1; rdy_a = 1'b1; mode_a = 1'b0; v_a = 4'b0110; d_a = 16'h0870;
        tick();
        chk("post_rst_ch", 32'(oc_a), 32'd1);

        // Random traffic; pending requests are held until accepted
        v_a = 4'h0; v_b = 3'h0;
        for (int it = 0; it < 400; it++) begin
            for (int c = 0; c < 4; c++) begin
                if (!(v_a[c] && last_g[0] != c)) begin
                    v_a[c] = ($urandom_range(0, 2) != 0);
                    d_a[c*4 +: 4] = 4'($urandom);
                end
            end
            for (int c = 0; c < 3; c++) begin
                if (!(v_b[c] && last_g[1] != c)) begin
                    v_b[c] = ($urandom_range(0, 2) != 0);
                    d_b[c*4 +: 4] = 4'($urandom);
                end
            end
            if ($urandom_range(0, 7) == 0) mode_a = ~mode_a;
            if ($urandom_range(0, 7) == 0) mode_b = ~mode_b;
            rdy_a = ($urandom_range(0, 3) != 0);
            rdy_b = ($urandom_range(0, 3) != 0);
            tick();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/rr_stream_mux.md
Name: rr_stream_mux

Overview:
Parametrised N-channel streaming multiplexer. It is the successor to the fixed 4:1 combinational mux.
- Each input channel carries valid/ready handshaked data.
- An internal arbiter picks one requesting channel per cycle: round-robin or fixed-priority.
- The winner's data is registered into a one-entry output stage, tagged with its channel index.
- Sits between multiple producers and a single downstream consumer.

Parameters:
N_CH, 4, number of input channels (2..16; need not be a power of two)
WIDTH, 4, data width per channel in bits
CH_W, $clog2(N_CH), width of channel index (derived, not overridden)

Ports:
clk  input  1  clock, all state updates on rising edge
rst_n  input  1  reset, asynchronous, active-low
mode  input  1  arbitration mode: 0 = round-robin, 1 = fixed priority (lowest index wins)
in_valid  input  N_CH  per-channel valid
in_data  input  N_CH*WIDTH  packed channel data; channel i at bits [i*WIDTH +: WIDTH]
in_ready  output  N_CH  per-channel ready (one-hot or zero)
out_valid  output  1  output register holds a word
out_data  output  WIDTH  registered data
out_ch  output  CH_W  index of the channel that supplied out_data
out_ready  input  1  downstream accepts word

Behaviour:
- Reset (rst_n low, asynchronous): out_valid=0, out_data=0, out_ch=0, rr pointer ptr=0.
  - in_ready is forced to all-zero while rst_n is low.
- Load condition: load = !out_valid || out_ready. The output stage accepts a new word when empty or draining in the same cycle.
- Grant is combinational from in_valid, ptr and mode.
  - mode=1: lowest-index valid channel wins.
  - mode=0: first valid channel at or after ptr, searching upward with wrap at N_CH-1 -> 0.
  - No valid channel -> no grant.
- in_ready[i] = load && grant[i]. At most one bit is set, and never for a channel with in_valid=0.
- Transfer on channel k when in_valid[k] && in_ready[k]. On the next edge:
  - out_valid=1, out_data=in_data[k], out_ch=k.
  - ptr=(k+1) mod N_CH in either mode; wrap is explicit for non-power-of-two N_CH.
- No transfer and out_ready=1 -> out_valid clears next edge. out_data and out_ch hold their last values.
- Stall (out_valid && !out_ready): out_data and out_ch are held stable, in_ready is all-zero, ptr does not change.
- Simultaneous drain and fill (out_valid && out_ready && input transfer): the word is replaced in the same edge, with no bubble.
- Throughput: 1 word/cycle with out_ready held high. Latency: 1 cycle from input handshake to out_valid.
- Fairness (mode=0): with all channels continuously valid, the grant order is 0,1,...,N_CH-1,0,...
- mode may change on any cycle. It affects the grant in that same cycle only, and ptr is never reset by a mode change.
- Producer rules: in_valid must not drop, and in_data must not change, until the handshake completes. The block does not check this.
- Reset asserted mid-stream: the pending output word is discarded and ptr returns to 0.

Decomposition:
- Package rr_stream_mux_pkg holds:
  - arb_mode_t enum (ARB_RR=1'b0, ARB_FIXED=1'b1)
  - a max-channels constant for the elaboration-time assertion 2<=N_CH<=16
- Sub-module rr_arbiter, purely combinational, parametrised by N_CH.
  - Inputs: req, ptr, mode.
  - Outputs: one-hot grant, grant_idx, any_grant.
  - Implementation: double-width rotate/mask or loop search.
- Top level contains only the output register, ptr register and handshake glue.

Test Plan:
- Reset and idle: rst_n low with in_valid=4'hF -> in_ready=0, out_valid=0, out_data=0. Release with in_valid=0 -> out_valid remains 0.
- Round-robin fairness: N_CH=4, mode=0, all valid, data_i=i+1, out_ready=1 -> out_ch sequence 0,1,2,3,0 and out_data 1,2,3,4,1 on consecutive cycles, one word per cycle.
- Fixed priority: mode=1, in_valid=4'b1010 held -> out_ch always 1. Drop ch1 -> out_ch=3 next transfer.
- Backpressure: out_ready=0 for 3 cycles with out_valid=1, out_data=4'h5 -> in_ready=0, out_data/out_ch stable. Raise out_ready with ch2 valid (data 4'hA) -> next cycle out_data=4'hA, out_ch=2.
- Wrap with non-power-of-two: N_CH=3, mode=0, only ch2 then ch0 valid -> after ch2 transfer ptr=0 and ch0 granted. Channels 0..2 all valid -> order 0,1,2,0.
- Async reset mid-stream: assert rst_n low between edges while out_valid=1 -> out_valid=0 immediately. After release, first grant in mode=0 goes to the lowest valid channel (ptr=0).
